// File: rtl/isp_exposure_engine.sv
// isp_exposure_engine: auto-exposure responder; takes a request (clk, rst, in_*), reads the picture over rd_*, writes it back rescaled over wr_*, reports the gray mean on out_*
module isp_exposure_engine #(
  parameter logic [16:0] BASE_ADDR = 17'h10000,
  parameter int PIC_BYTES = 3072,
  parameter int BEATS = 192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   in_pic_no,
  input  logic [1:0]   in_ratio_mode,
  output logic         rd_addr_valid,
  input  logic         rd_addr_ready,
  output logic [16:0]  rd_addr,
  input  logic         rd_data_valid,
  output logic         rd_data_ready,
  input  logic [127:0] rd_data,
  output logic         wr_addr_valid,
  input  logic         wr_addr_ready,
  output logic [16:0]  wr_addr,
  output logic         wr_data_valid,
  input  logic         wr_data_ready,
  output logic [127:0] wr_data,
  output logic         wr_last,
  output logic         out_valid,
  output logic [7:0]   out_data
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, WR_ADDR, STREAM, DRAIN, DONE} state_t;
  state_t state, next;
  logic [16:0] addr;
  logic [1:0] ratio;
  logic [7:0] beat;
  logic [17:0] acc;
  logic [127:0] scaled;
  logic [11:0] beat_sum;
  logic [7:0] p, s;
  logic rd_fire, wr_fire, is_g, last_beat;
  assign rd_data_ready = (state == STREAM) && (!wr_data_valid || wr_data_ready);
  assign rd_fire = rd_data_valid && rd_data_ready;
  assign wr_fire = wr_data_valid && wr_data_ready;
  assign last_beat = beat == 8'(BEATS - 1);
  assign is_g = beat >= 8'd64 && beat < 8'd128;
  assign rd_addr_valid = state == RD_ADDR;
  assign wr_addr_valid = state == WR_ADDR;
  assign rd_addr = addr;
  assign wr_addr = addr;
  assign out_valid = state == DONE;
  assign out_data = out_valid ? acc[17:10] : 8'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in_valid ? RD_ADDR : IDLE;
      RD_ADDR: next = rd_addr_ready ? WR_ADDR : RD_ADDR;
      WR_ADDR: next = wr_addr_ready ? STREAM : WR_ADDR;
      STREAM:  next = (rd_fire && last_beat) ? DRAIN : STREAM;
      DRAIN:   next = (wr_fire && wr_last) ? DONE : DRAIN;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    scaled = '0;
    beat_sum = '0;
    p = '0;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      p = rd_data[8*k +: 8];
      s = ratio == 2'd0 ? p >> 2 : ratio == 2'd1 ? p >> 1 : ratio == 2'd2 ? p : (p[7] ? 8'hFF : {p[6:0], 1'b0});
      scaled[8*k +: 8] = s;
      beat_sum = beat_sum + (is_g ? 12'(s >> 1) : 12'(s >> 2));
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      ratio <= '0;
      beat <= '0;
      acc <= '0;
      wr_data <= '0;
      wr_data_valid <= 1'b0;
      wr_last <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        addr <= BASE_ADDR + 17'(in_pic_no) * 17'(PIC_BYTES);
        ratio <= in_ratio_mode;
        acc <= '0;
      end
      if (rd_fire) begin
        wr_data <= scaled;
        wr_data_valid <= 1'b1;
        wr_last <= last_beat;
        beat <= last_beat ? 8'd0 : beat + 8'd1;
        acc <= acc + 18'(beat_sum);
      end else if (wr_fire) begin
        wr_data_valid <= 1'b0;
        wr_last <= 1'b0;
      end
    end
endmodule
